// File: rtl/float_to_fixed_if.sv
// Handshake bundle for float_to_fixed: the operand goes in on stb/ack, the fixed-point result comes out on stb/ack.
// The producer/consumer side takes the master modport and the converter takes the slave modport.
interface float_to_fixed_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_sat;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a,
        output input_a_stb,
        output output_z_ack,
        input  input_a_ack,
        input  output_z,
        input  output_z_sat,
        input  output_z_stb
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        input  output_z_ack,
        output input_a_ack,
        output output_z,
        output output_z_sat,
        output output_z_stb
    );
endinterface

// File: rtl/float_to_fixed.sv
// IEEE-754 single to saturated 32-bit signed fixed point with FRAC_BITS fraction bits.
// The value is aligned one bit per cycle and then rounded to nearest-even.
module float_to_fixed #(
    parameter int FRAC_BITS = 16
) (
    input logic         clk,
    input logic         rst,
    float_to_fixed_if.slave bus
);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        SPECIAL_CASES,
        ALIGN,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    localparam logic signed [9:0] FB = 10'(FRAC_BITS);

    state_t state, state_next;

    logic [31:0]        a;
    logic               s;
    logic signed [9:0]  e;
    logic [23:0]        m;
    logic [31:0]        mag;
    logic               guard;
    logic               sticky;
    logic [9:0]         count;
    logic               shift_left;
    logic [31:0]        z;
    logic               sat;
    logic               a_ack;
    logic               z_stb;

    logic signed [9:0]  e_fb;
    logic signed [9:0]  shift;
    logic [9:0]         shift_abs;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
    logic               is_min_neg;
    logic               early_out;

    assign e_fb       = e + FB;
    assign shift      = e_fb - 10'sd23;
    assign shift_abs  = shift[9] ? (~shift + 10'd1) : shift;
    assign is_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign is_inf     = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign is_zero    = (a[30:0] == 31'd0);
    assign is_min_neg = s && (m == 24'h800000);
    // Exactly -2^31 is the only operand with e+FB = 31 that fits; it still takes the early exit.
    assign early_out  = is_nan || is_inf || is_zero || (e_fb >= 10'sd31) || (shift < -10'sd25);

    assign bus.input_a_ack  = a_ack;
    assign bus.output_z     = z;
    assign bus.output_z_sat = sat;
    assign bus.output_z_stb = z_stb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            GET_A:         if (a_ack && bus.input_a_stb) state_next = UNPACK;
            UNPACK:        state_next = SPECIAL_CASES;
            SPECIAL_CASES: state_next = early_out ? PUT_Z : ALIGN;
            ALIGN:         if (count <= 10'd1) state_next = ROUND;
            ROUND:         state_next = PACK;
            PACK:          state_next = PUT_Z;
            PUT_Z:         if (z_stb && bus.output_z_ack) state_next = GET_A;
            default:       state_next = GET_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a          <= 32'd0;
            s          <= 1'b0;
            e          <= 10'sd0;
            m          <= 24'd0;
            mag        <= 32'd0;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            count      <= 10'd0;
            shift_left <= 1'b0;
            z          <= 32'd0;
            sat        <= 1'b0;
            a_ack      <= 1'b0;
            z_stb      <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    a_ack <= 1'b1;
                    if (a_ack && bus.input_a_stb) begin
                        a     <= bus.input_a;
                        a_ack <= 1'b0;
                    end
                end
                UNPACK: begin
                    s <= a[31];
                    if (a[30:23] == 8'd0) begin
                        e <= -10'sd126;
                        m <= {1'b0, a[22:0]};
                    end else begin
                        e <= $signed({2'b00, a[30:23]}) - 10'sd127;
                        m <= {1'b1, a[22:0]};
                    end
                end
                SPECIAL_CASES: begin
                    if (is_nan) begin
                        z   <= 32'd0;
                        sat <= 1'b1;
                    end else if (is_inf) begin
                        z   <= s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        sat <= 1'b1;
                    end else if (is_zero) begin
                        z   <= 32'd0;
                        sat <= 1'b0;
                    end else if ((e_fb > 10'sd31) || ((e_fb == 10'sd31) && !is_min_neg)) begin
                        z   <= s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        sat <= 1'b1;
                    end else if (e_fb == 10'sd31) begin
                        z   <= 32'h8000_0000;
                        sat <= 1'b0;
                    end else if (shift < -10'sd25) begin
                        z   <= 32'd0;
                        sat <= 1'b0;
                    end else begin
                        mag        <= {8'd0, m};
                        guard      <= 1'b0;
                        sticky     <= 1'b0;
                        count      <= shift_abs;
                        shift_left <= !shift[9];
                    end
                end
                ALIGN: begin
                    if (count != 10'd0) begin
                        count <= count - 10'd1;
                        if (shift_left) begin
                            mag <= mag << 1;
                        end else begin
                            mag    <= mag >> 1;
                            guard  <= mag[0];
                            sticky <= sticky | guard;
                        end
                    end
                end
                ROUND: begin
                    if (guard && (sticky || mag[0])) mag <= mag + 32'd1;
                end
                PACK: begin
                    z   <= s ? (~mag + 32'd1) : mag;
                    sat <= 1'b0;
                end
                PUT_Z: begin
                    z_stb <= 1'b1;
                    if (z_stb && bus.output_z_ack) z_stb <= 1'b0;
                end
                default: begin
                    a_ack <= 1'b0;
                    z_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Testbench for float_to_fixed: one instance with FRAC_BITS=16 and one with FRAC_BITS=0, both checked against a value-level model.
// Directed operands are pinned to hand-computed results, and a single compare process checks every cycle that output_z_stb is high.
module tb_float_to_fixed;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    float_to_fixed_if bus16 ();
    float_to_fixed_if bus0 ();

    float_to_fixed #(.FRAC_BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    float_to_fixed #(.FRAC_BITS(0))  dut0  (.clk(clk), .rst(rst), .bus(bus0.slave));

    logic [31:0] a_drv [2];
    logic        a_stb [2];
    logic        z_ack [2];
    logic        a_ack [2];
    logic [31:0] z_out [2];
    logic        z_sat [2];
    logic        z_stb [2];

    assign bus16.input_a      = a_drv[0];
    assign bus16.input_a_stb  = a_stb[0];
    assign bus16.output_z_ack = z_ack[0];
    assign bus0.input_a       = a_drv[1];
    assign bus0.input_a_stb   = a_stb[1];
    assign bus0.output_z_ack  = z_ack[1];
    assign a_ack[0] = bus16.input_a_ack;
    assign z_out[0] = bus16.output_z;
    assign z_sat[0] = bus16.output_z_sat;
    assign z_stb[0] = bus16.output_z_stb;
    assign a_ack[1] = bus0.input_a_ack;
    assign z_out[1] = bus0.output_z;
    assign z_sat[1] = bus0.output_z_sat;
    assign z_stb[1] = bus0.output_z_stb;

    typedef struct {
        int          d;
        logic [31:0] z;
        logic        sat;
    } exp_t;

    exp_t exp_q [$];
    int   frac [2] = '{16, 0};
    int   results_seen [2] = '{0, 0};
    int   assert_count = 0;
    int   fail_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Exact value m * 2^k rounded half-to-even with integer arithmetic, then clipped to 32 bits.
    function automatic void model(input int fb, input logic [31:0] a,
                                  output logic [31:0] z, output logic sat, output int lat);
        int     ef, e, k, n, ak;
        longint m, q, rem, half, v;
        z   = 32'd0;
        sat = 1'b0;
        lat = 3;
        ef  = int'(a[30:23]);
        if (ef == 255) begin
            sat = 1'b1;
            if (a[22:0] == 23'd0) z = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        if (a[30:0] == 31'd0) return;
        if (ef == 0) begin
            m = longint'(a[22:0]);
            e = -126;
        end else begin
            m = longint'({1'b1, a[22:0]});
            e = ef - 127;
        end
        k = e - 23 + fb;
        if (k >= 40) begin
            q = 64'sd1 <<< 50;
        end else if (k >= 0) begin
            q = m <<< k;
        end else begin
            n = -k;
            if (n > 40) begin
                q = 0;
            end else begin
                q    = m >>> n;
                rem  = m - (q <<< n);
                half = 64'sd1 <<< (n - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
            end
        end
        v = a[31] ? -q : q;
        if (v > 64'sd2147483647) begin
            z   = 32'h7FFF_FFFF;
            sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            z   = 32'h8000_0000;
            sat = 1'b1;
        end else begin
            z = v[31:0];
        end
        ak = (k < 0) ? -k : k;
        if ((e + fb) < 31 && k >= -25) lat = 5 + ((ak > 1) ? ak : 1);
    endfunction

    always @(negedge clk) begin
        exp_t ex;
        for (int d = 0; d < 2; d++) begin
            if (z_stb[d] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].d != d) begin
                    assert_count++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_result dut%0d: got 0x%08h sat=%0b, required no result", d, z_out[d], z_sat[d]);
                end else begin
                    ex = exp_q[0];
                    checkOutput($sformatf("output_z dut%0d", d), z_out[d], ex.z);
                    checkOutput($sformatf("output_z_sat dut%0d", d), 32'(z_sat[d]), 32'(ex.sat));
                    if (z_ack[d] === 1'b1) begin
                        void'(exp_q.pop_front());
                        results_seen[d]++;
                    end
                end
            end
        end
    end

    task automatic waitAccept(input int d, output bit ok);
        int waited = 0;
        while (a_ack[d] !== 1'b1 && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = (a_ack[d] === 1'b1);
        if (!ok) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL accept_timeout dut%0d: input_a_ack=%0b, required 1", d, a_ack[d]);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] exp_z,
                                 input logic exp_sat, input int hold);
        logic [31:0] mz;
        logic        ms;
        int          lat;
        int          cnt;
        bit          ok;
        exp_t        ex;
        model(frac[d], a, mz, ms, lat);
        checkOutput($sformatf("model_z %08h", a), mz, exp_z);
        checkOutput($sformatf("model_sat %08h", a), 32'(ms), 32'(exp_sat));
        ex.d = d; ex.z = mz; ex.sat = ms;
        exp_q.push_back(ex);
        a_drv[d] = a;
        a_stb[d] = 1'b1;
        waitAccept(d, ok);
        a_stb[d] = 1'b0;
        if (!ok) begin
            void'(exp_q.pop_back());
            return;
        end
        cnt = 0;
        while (z_stb[d] !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput($sformatf("latency %08h", a), 32'(cnt), 32'(lat));
        repeat (hold) begin
            checkOutput("stb_held", 32'(z_stb[d]), 32'd1);
            @(posedge clk); #1;
        end
        z_ack[d] = 1'b1;
        @(posedge clk); #1;
        z_ack[d] = 1'b0;
        checkOutput("stb_drop", 32'(z_stb[d]), 32'd0);
        checkOutput("ack_still_low", 32'(a_ack[d]), 32'd0);
        @(posedge clk); #1;
        checkOutput("ack_rise", 32'(a_ack[d]), 32'd1);
    endtask

    task automatic backToBack(input int d, input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        logic [31:0] vals [3];
        logic [31:0] mz;
        logic        ms;
        int          lat;
        int          start;
        int          waited;
        bit          ok;
        exp_t        ex;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        start = results_seen[d];
        for (int i = 0; i < 3; i++) begin
            model(frac[d], vals[i], mz, ms, lat);
            ex.d = d; ex.z = mz; ex.sat = ms;
            exp_q.push_back(ex);
        end
        z_ack[d] = 1'b1;
        a_stb[d] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_drv[d] = vals[i];
            waitAccept(d, ok);
        end
        a_stb[d] = 1'b0;
        waited = 0;
        while (results_seen[d] < start + 3 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (20) @(posedge clk);
        #1;
        z_ack[d] = 1'b0;
        checkOutput("b2b_result_count", 32'(results_seen[d] - start), 32'd3);
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] mz;
        logic        ms;
        int          lat;
        bit          ok;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            a_drv[d] = 32'd0;
            a_stb[d] = 1'b0;
            z_ack[d] = 1'b0;
        end
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset_ack dut%0d", d), 32'(a_ack[d]), 32'd0);
            checkOutput($sformatf("reset_stb dut%0d", d), 32'(z_stb[d]), 32'd0);
            checkOutput($sformatf("reset_z dut%0d", d), z_out[d], 32'd0);
            checkOutput($sformatf("reset_sat dut%0d", d), 32'(z_sat[d]), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        model(16, 32'h3FC0_0000, mz, ms, lat);
        checkOutput("model_latency_1p5", 32'(lat), 32'd12);
        model(16, 32'h7F80_0000, mz, ms, lat);
        checkOutput("model_latency_inf", 32'(lat), 32'd3);

        applyStimulus(0, 32'h3FC0_0000, 32'h0001_8000, 1'b0, 0);
        applyStimulus(0, 32'hC010_0000, 32'hFFFD_C000, 1'b0, 0);

        applyStimulus(1, 32'h4020_0000, 32'h0000_0002, 1'b0, 0);
        applyStimulus(1, 32'hBF00_0000, 32'h0000_0000, 1'b0, 0);
        applyStimulus(1, 32'h3F7F_FFFF, 32'h0000_0001, 1'b0, 0);
        applyStimulus(1, 32'h4060_0000, 32'h0000_0004, 1'b0, 0);

        applyStimulus(0, 32'h4780_0000, 32'h7FFF_FFFF, 1'b1, 0);
        applyStimulus(0, 32'hC700_0000, 32'h8000_0000, 1'b0, 0);
        applyStimulus(0, 32'hC700_0001, 32'h8000_0000, 1'b1, 0);

        applyStimulus(0, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 0);
        applyStimulus(0, 32'hFF80_0000, 32'h8000_0000, 1'b1, 0);
        applyStimulus(0, 32'h7FC0_0000, 32'h0000_0000, 1'b1, 0);
        applyStimulus(0, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);
        applyStimulus(0, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);

        applyStimulus(0, 32'hC010_0000, 32'hFFFD_C000, 1'b0, 6);
        backToBack(0, 32'h3FC0_0000, 32'hC010_0000, 32'h7FC0_0000);

        // Abort a long alignment on the FRAC_BITS=0 instance; its last result (4) must vanish at once.
        a_drv[1] = 32'h3F80_0001;
        a_stb[1] = 1'b1;
        waitAccept(1, ok);
        a_stb[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_reset_z", z_out[1], 32'h0000_0004);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_reset_stb", 32'(z_stb[1]), 32'd0);
        checkOutput("async_reset_ack", 32'(a_ack[1]), 32'd0);
        checkOutput("async_reset_z", z_out[1], 32'd0);
        checkOutput("async_reset_sat", 32'(z_sat[1]), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 32'h4040_0000, 32'h0000_0003, 1'b0, 0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
